// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Single-port SRAM controller. Turns one byte-addressed valid/ready request
// into SRAM pin cycles (CEN/WEN/A/D/Q) and returns the result on a
// valid/ready response channel. Only one transaction is in flight at a time.
//
// Optional feature macro: SRAM_CTRL_RMW_EN
//   defined   : partial-strobe writes run as read-modify-write; rsp_err is 0.
//   undefined : partial-strobe writes are rejected with rsp_err=1 and never
//               touch the SRAM.
// -----------------------------------------------------------------------------
module sram_ctrl #(
   parameter  int DATAWIDTH = 32,
   parameter  int ADDRWIDTH = 18,
   localparam int OFFW      = $clog2(DATAWIDTH/8),
   localparam int NBYTES    = DATAWIDTH/8
) (
   input  logic                      CLK,
   input  logic                      RSTN,
   // core request channel
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDRWIDTH+OFFW-1:0] req_addr,
   input  logic [DATAWIDTH-1:0]      req_wdata,
   input  logic [NBYTES-1:0]         req_wstrb,
   // core response channel
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATAWIDTH-1:0]      rsp_rdata,
   output logic                      rsp_err,
   // SRAM pins
   output logic                      sram_CEN,
   output logic                      sram_WEN,
   output logic [ADDRWIDTH-1:0]      sram_A,
   output logic [DATAWIDTH-1:0]      sram_D,
   input  logic [DATAWIDTH-1:0]      sram_Q
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_CAP,
      WR,
`ifdef SRAM_CTRL_RMW_EN
      RMW_RD,
      RMW_MRG,
      RMW_WR,
`endif
      RESP
   } state_e;

   state_e state_q, state_d;

   // Pin and response registers
   logic                 sram_cen_q, sram_cen_d;
   logic                 sram_wen_q, sram_wen_d;
   logic [ADDRWIDTH-1:0] sram_a_q,   sram_a_d;
   logic [DATAWIDTH-1:0] sram_d_q,   sram_d_d;
   logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   // Request decode
   logic                 accept;
   logic [ADDRWIDTH-1:0] req_word;
   logic                 strb_full;
   logic                 strb_zero;
   logic                 unused_addr_off;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid & req_ready;
   assign req_word  = req_addr[ADDRWIDTH+OFFW-1:OFFW];
   assign strb_full = &req_wstrb;
   assign strb_zero = ~|req_wstrb;

   // The byte offset inside a word never reaches the SRAM.
   assign unused_addr_off = ^req_addr[OFFW-1:0];

`ifdef SRAM_CTRL_RMW_EN
   // Write fields kept for the merge step, plus the merged word itself.
   logic [DATAWIDTH-1:0] wdata_q, wdata_d;
   logic [NBYTES-1:0]    wstrb_q, wstrb_d;
   logic [DATAWIDTH-1:0] merged;

   assign rsp_err = 1'b0;
`else
   logic                 rsp_err_q, rsp_err_d;

   assign rsp_err = rsp_err_q;
`endif

   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign sram_CEN  = sram_cen_q;
   assign sram_WEN  = sram_wen_q;
   assign sram_A    = sram_a_q;
   assign sram_D    = sram_d_q;

   // State register; reset returns to IDLE without waiting for a clock.
   always_ff @(posedge CLK or negedge RSTN) begin
      // NOTE: sequential state is only ever written with <= so every flop
      // samples the pre-edge values of its neighbours.
      if (!RSTN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: route each accepted request down its access path.
   always_comb begin
      // NOTE: defaults first, so no branch leaves state_d unassigned and
      // no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!req_write) begin
                  state_d = RD;
               end else if (strb_full) begin
                  state_d = WR;
               end else if (strb_zero) begin
                  state_d = RESP;
               end else begin
`ifdef SRAM_CTRL_RMW_EN
                  state_d = RMW_RD;
`else
                  state_d = RESP;
`endif
               end
            end
         end
         RD:      state_d = RD_CAP;
         RD_CAP:  state_d = RESP;
         WR:      state_d = RESP;
`ifdef SRAM_CTRL_RMW_EN
         RMW_RD:  state_d = RMW_MRG;
         RMW_MRG: state_d = RMW_WR;
         RMW_WR:  state_d = RESP;
`endif
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SRAM_CTRL_RMW_EN
   // Byte merge: strobed bytes come from the request, the rest from the SRAM.
   always_comb begin
      merged = sram_Q;
      for (int i = 0; i < NBYTES; i++) begin
         if (wstrb_q[i]) begin
            merged[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end
`endif

   // Datapath next values. Pin strobes follow the upcoming state so the
   // registered pins line up with the state they belong to.
   always_comb begin
      sram_cen_d  = 1'b1;
      sram_wen_d  = 1'b1;
      sram_a_d    = sram_a_q;
      sram_d_d    = sram_d_q;
      rsp_rdata_d = rsp_rdata_q;
`ifdef SRAM_CTRL_RMW_EN
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
`else
      rsp_err_d   = rsp_err_q;
`endif

      case (state_d)
         RD: begin
            sram_cen_d = 1'b0;
         end
         WR: begin
            sram_cen_d = 1'b0;
            sram_wen_d = 1'b0;
         end
`ifdef SRAM_CTRL_RMW_EN
         RMW_RD: begin
            sram_cen_d = 1'b0;
         end
         RMW_WR: begin
            sram_cen_d = 1'b0;
            sram_wen_d = 1'b0;
         end
`endif
         default: begin
            sram_cen_d = 1'b1;
            sram_wen_d = 1'b1;
         end
      endcase

      // The address only moves when a pin cycle actually follows, so a
      // zero-strobe or rejected write leaves sram_A untouched.
      if (accept && (state_d != RESP)) begin
         sram_a_d = req_word;
      end

      // Full writes drive the request data straight onto the pins.
      if (accept && req_write && strb_full) begin
         sram_d_d = req_wdata;
      end

`ifdef SRAM_CTRL_RMW_EN
      if (accept) begin
         wdata_d = req_wdata;
         wstrb_d = req_wstrb;
      end
      if (state_q == RMW_MRG) begin
         sram_d_d = merged;
      end
`else
      if (accept) begin
         rsp_err_d = req_write & ~strb_full & ~strb_zero;
      end else if ((state_q == RESP) && rsp_ready) begin
         rsp_err_d = 1'b0;
      end
`endif

      // Reads capture the SRAM output; every write path enters RESP with 0.
      if (state_q == RD_CAP) begin
         rsp_rdata_d = sram_Q;
      end else if ((state_d == RESP) && (state_q != RESP)) begin
         rsp_rdata_d = '0;
      end
   end

   // Datapath registers; CEN/WEN drop to idle asynchronously on reset,
   // which abandons any pin cycle the SRAM has not yet sampled.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sram_cen_q  <= 1'b1;
         sram_wen_q  <= 1'b1;
         sram_a_q    <= '0;
         sram_d_q    <= '0;
         rsp_rdata_q <= '0;
`ifdef SRAM_CTRL_RMW_EN
         wdata_q     <= '0;
         wstrb_q     <= '0;
`else
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         sram_cen_q  <= sram_cen_d;
         sram_wen_q  <= sram_wen_d;
         sram_a_q    <= sram_a_d;
         sram_d_q    <= sram_d_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef SRAM_CTRL_RMW_EN
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
`else
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Drives sram_ctrl against a behavioural single-port SRAM and a transaction
// level reference memory. Expected data, latency and pin activity are derived
// from the controller's documented rules; SRAM_CTRL_RMW_EN selects which
// partial-write behaviour is expected.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

   localparam int DW   = 32;
   localparam int AW   = 18;
   localparam int BW   = DW/8;
   localparam int OFFW = $clog2(BW);
   localparam int BAW  = AW + OFFW;

   logic            CLK;
   logic            RSTN;
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [BAW-1:0]  req_addr;
   logic [DW-1:0]   req_wdata;
   logic [BW-1:0]   req_wstrb;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;
   logic            sram_CEN;
   logic            sram_WEN;
   logic [AW-1:0]   sram_A;
   logic [DW-1:0]   sram_D;
   logic [DW-1:0]   sram_Q;

   int n_vec = 0;
   int n_mis = 0;

   sram_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .sram_CEN  (sram_CEN),
      .sram_WEN  (sram_WEN),
      .sram_A    (sram_A),
      .sram_D    (sram_D),
      .sram_Q    (sram_Q)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------------------------------------------------------------
   // Behavioural SRAM: Q carries the addressed word only in the cycle after
   // a read pin cycle and is zero otherwise. Also logs pin activity.
   // ---------------------------------------------------------------------
   logic [DW-1:0] sram_mem [logic [AW-1:0]];
   int unsigned   cen_cnt = 0;
   int unsigned   wen_cnt = 0;
   logic [AW-1:0] last_a  = '0;

   function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
      return sram_mem.exists(a) ? sram_mem[a] : '0;
   endfunction

   initial sram_Q = '0;

   always @(posedge CLK) begin
      if (!sram_CEN) begin
         cen_cnt++;
         last_a = sram_A;
         if (!sram_WEN) begin
            wen_cnt++;
            sram_mem[sram_A] = sram_D;
            sram_Q <= '0;
         end else begin
            sram_Q <= sram_rd(sram_A);
         end
      end else begin
         sram_Q <= '0;
      end
   end

   // ---------------------------------------------------------------------
   // Reference memory, updated once per transaction from the written rules.
   // ---------------------------------------------------------------------
   logic [DW-1:0] ref_mem [logic [AW-1:0]];

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0;
      req_write = 1'(  $urandom);
      req_addr  = BAW'($urandom);
      req_wdata = DW'( $urandom);
      req_wstrb = BW'( $urandom);
   endtask

   // One complete transaction: handshake, latency, response, backpressure,
   // pin activity and resulting memory contents.
   task automatic do_txn(input string name, input logic wr, input logic [BAW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [BW-1:0] wstrb,
                         input int stall);
      logic [AW-1:0] word;
      logic [DW-1:0] old_w, exp_rdata, exp_mem;
      logic          exp_err;
      int            exp_lat, exp_cen, exp_wen, lat, wait_cnt;
      int unsigned   cen0, wen0;

      word      = addr[BAW-1:OFFW];
      old_w     = ref_rd(word);
      exp_rdata = '0;
      exp_err   = 1'b0;
      exp_mem   = old_w;
      if (!wr) begin
         exp_rdata = old_w; exp_lat = 3; exp_cen = 1; exp_wen = 0;
      end else if (wstrb == {BW{1'b1}}) begin
         exp_mem = wdata;   exp_lat = 2; exp_cen = 1; exp_wen = 1;
      end else if (wstrb == '0) begin
         exp_lat = 1; exp_cen = 0; exp_wen = 0;
      end else begin
`ifdef SRAM_CTRL_RMW_EN
         for (int b = 0; b < BW; b++) begin
            if (wstrb[b]) exp_mem[8*b +: 8] = wdata[8*b +: 8];
         end
         exp_lat = 4; exp_cen = 2; exp_wen = 1;
`else
         exp_err = 1'b1; exp_lat = 1; exp_cen = 0; exp_wen = 0;
`endif
      end
      ref_mem[word] = exp_mem;

      wait_cnt = 0;
      while (req_ready !== 1'b1 && wait_cnt < 20) begin
         tick();
         wait_cnt++;
      end
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL %s req_ready before request: got %b want 1", name, req_ready);
      end

      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = wstrb;
      rsp_ready = 1'b0;
      cen0      = cen_cnt;
      wen0      = wen_cnt;
      tick();
      idle_inputs();

      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 12) begin
         n_vec++;
         if (req_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL %s req_ready while busy: got %b want 0", name, req_ready);
         end
         tick();
         lat++;
      end
      n_vec++;
      if (lat != exp_lat || rsp_valid !== 1'b1) begin
         n_mis++;
         $display("FAIL %s latency: got %0d (rsp_valid=%b) want %0d", name, lat, rsp_valid, exp_lat);
      end
      n_vec++;
      if (rsp_rdata !== exp_rdata) begin
         n_mis++;
         $display("FAIL %s rsp_rdata: got %h want %h", name, rsp_rdata, exp_rdata);
      end
      n_vec++;
      if (rsp_err !== exp_err) begin
         n_mis++;
         $display("FAIL %s rsp_err: got %b want %b", name, rsp_err, exp_err);
      end

      for (int s = 0; s < stall; s++) begin
         tick();
         n_vec++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
             req_ready !== 1'b0 || sram_CEN !== 1'b1) begin
            n_mis++;
            $display("FAIL %s stall cycle %0d: valid=%b rdata=%h err=%b ready=%b cen=%b want 1 %h %b 0 1",
                     name, s, rsp_valid, rsp_rdata, rsp_err, req_ready, sram_CEN, exp_rdata, exp_err);
         end
      end

      rsp_ready = 1'b1;
      n_vec++;
      if (req_ready !== 1'b0) begin
         n_mis++;
         $display("FAIL %s req_ready with rsp_ready high: got %b want 0", name, req_ready);
      end
      tick();
      rsp_ready = 1'b0;
      n_vec++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL %s after response: valid=%b ready=%b want 0 1", name, rsp_valid, req_ready);
      end

      n_vec++;
      if (int'(cen_cnt - cen0) != exp_cen || int'(wen_cnt - wen0) != exp_wen) begin
         n_mis++;
         $display("FAIL %s pin cycles: cen=%0d wen=%0d want %0d %0d",
                  name, cen_cnt - cen0, wen_cnt - wen0, exp_cen, exp_wen);
      end
      if (exp_cen > 0) begin
         n_vec++;
         if (last_a !== word) begin
            n_mis++;
            $display("FAIL %s sram_A: got %h want %h", name, last_a, word);
         end
      end
      n_vec++;
      if (sram_rd(word) !== exp_mem) begin
         n_mis++;
         $display("FAIL %s memory word %h: got %h want %h", name, word, sram_rd(word), exp_mem);
      end
   endtask

   // ---------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------
   task automatic test_reset();
      RSTN      = 1'b0;
      rsp_ready = 1'b0;
      idle_inputs();
      #23;
      n_vec++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 ||
          sram_CEN !== 1'b1 || sram_WEN !== 1'b1 || sram_A !== '0 || sram_D !== '0) begin
         n_mis++;
         $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b cen=%b wen=%b A=%h D=%h",
                  req_ready, rsp_valid, rsp_rdata, rsp_err, sram_CEN, sram_WEN, sram_A, sram_D);
      end
      RSTN = 1'b1;
      tick();
      tick();
      n_vec++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || sram_CEN !== 1'b1 ||
          sram_WEN !== 1'b1 || sram_A !== '0) begin
         n_mis++;
         $display("FAIL idle_after_reset: ready=%b valid=%b cen=%b wen=%b A=%h want 1 0 1 1 0",
                  req_ready, rsp_valid, sram_CEN, sram_WEN, sram_A);
      end
   endtask

   task automatic test_reset_during_read();
      int unsigned cen0;
      cen0      = cen_cnt;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = BAW'('h200);
      tick();
      idle_inputs();
      n_vec++;
      if (sram_CEN !== 1'b0) begin
         n_mis++;
         $display("FAIL rd_pin_cycle: sram_CEN got %b want 0", sram_CEN);
      end
      #2 RSTN = 1'b0;
      #1;
      n_vec++;
      if (sram_CEN !== 1'b1 || sram_WEN !== 1'b1 || req_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL async_reset_in_rd: cen=%b wen=%b ready=%b want 1 1 1", sram_CEN, sram_WEN, req_ready);
      end
      #1 RSTN = 1'b1;
      tick();
      tick();
      n_vec++;
      if (rsp_valid !== 1'b0 || cen_cnt != cen0 || req_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL dropped_read: valid=%b sram accesses=%0d ready=%b want 0 0 1",
                  rsp_valid, cen_cnt - cen0, req_ready);
      end
   endtask

   task automatic test_full_write_read();
      do_txn("full_write", 1'b1, BAW'('h100), 32'hDEADBEEF, 4'hF, 0);
      n_vec++;
      if (sram_rd(AW'('h40)) !== 32'hDEADBEEF) begin
         n_mis++;
         $display("FAIL full_write_word40: got %h want deadbeef", sram_rd(AW'('h40)));
      end
      do_txn("full_read", 1'b0, BAW'('h100), '0, '0, 0);
   endtask

   task automatic test_partial_write();
      logic [DW-1:0] want;
      do_txn("preload", 1'b1, BAW'('h100), 32'h11223344, 4'hF, 0);
      do_txn("partial_write", 1'b1, BAW'('h100), 32'hAABBCCDD, 4'b0101, 0);
`ifdef SRAM_CTRL_RMW_EN
      want = 32'h11BB33DD;
`else
      want = 32'h11223344;
`endif
      n_vec++;
      if (sram_rd(AW'('h40)) !== want) begin
         n_mis++;
         $display("FAIL partial_word40: got %h want %h", sram_rd(AW'('h40)), want);
      end
   endtask

   task automatic test_backpressure();
      do_txn("backpressure_read", 1'b0, BAW'('h100), '0, '0, 5);
   endtask

   task automatic test_zero_strobe_offset();
      do_txn("zero_strobe", 1'b1, BAW'('h100), 32'hCAFEF00D, 4'h0, 0);
      do_txn("offset_read", 1'b0, BAW'('h103), '0, '0, 0);
      n_vec++;
      if (last_a !== AW'('h40)) begin
         n_mis++;
         $display("FAIL offset_addr: sram_A got %h want 40", last_a);
      end
   endtask

`ifdef SRAM_CTRL_RMW_EN
   task automatic test_reset_during_rmw();
      do_txn("rmw_preload", 1'b1, BAW'('h180), 32'h55667788, 4'hF, 0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = BAW'('h180);
      req_wdata = 32'h01020304;
      req_wstrb = 4'b0011;
      tick();
      idle_inputs();
      tick();
      tick();
      #2 RSTN = 1'b0;
      #1;
      n_vec++;
      if (sram_CEN !== 1'b1 || sram_WEN !== 1'b1) begin
         n_mis++;
         $display("FAIL async_reset_in_rmw: cen=%b wen=%b want 1 1", sram_CEN, sram_WEN);
      end
      #1 RSTN = 1'b1;
      tick();
      tick();
      n_vec++;
      if (sram_rd(AW'('h60)) !== 32'h55667788) begin
         n_mis++;
         $display("FAIL rmw_reset_memory: got %h want 55667788", sram_rd(AW'('h60)));
      end
   endtask
`endif

   task automatic test_random();
      logic [BAW-1:0] a;
      logic [BW-1:0]  s;
      logic           w;
      for (int i = 0; i < 60; i++) begin
         a = {AW'('h40 + $urandom_range(0, 7)), OFFW'($urandom)};
         w = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       s = '1;
            1:       s = '0;
            default: s = BW'($urandom);
         endcase
         do_txn($sformatf("random_%0d", i), w, a, DW'($urandom), s, $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_reset_during_read();
      test_full_write_read();
      test_partial_write();
      test_backpressure();
      test_zero_strobe_offset();
`ifdef SRAM_CTRL_RMW_EN
      test_reset_during_rmw();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
